// File: rtl/ship_vga_pkg.sv
// Shared VGA timing defaults, coordinate types and the rectangle span helper
// used by the ship rectangle renderer.
package ship_vga_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // 11 bits so that a 10-bit position plus a 10-bit size never wraps.
    typedef logic [10:0] coord_t;
    typedef logic [23:0] rgb_t;

    typedef struct packed {
        coord_t px;
        coord_t py;
        coord_t sx;
        coord_t sy;
    } rect_t;

    function automatic logic in_span(coord_t c, coord_t lo, coord_t len);
        return (c >= lo) && (c < lo + len);
    endfunction

endpackage

// File: rtl/ship_rect_vga_if.sv
// Rectangle configuration inputs and VGA output bundle of ship_rect_vga.
// master drives the configuration, slave (the renderer) drives the VGA side.
interface ship_rect_vga_if;
    import ship_vga_pkg::*;

    logic [9:0] size_x;
    logic [9:0] size_y;
    logic [9:0] pos_x;
    logic [9:0] pos_y;
    rgb_t       fg_rgb;
    rgb_t       bg_rgb;

    logic       vga_hs;
    logic       vga_vs;
    logic       vga_blank_n;
    logic [7:0] vga_r;
    logic [7:0] vga_g;
    logic [7:0] vga_b;
    logic       frame_start;

    modport master (
        output size_x, size_y, pos_x, pos_y, fg_rgb, bg_rgb,
        input  vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start
    );

    modport slave (
        input  size_x, size_y, pos_x, pos_y, fg_rgb, bg_rgb,
        output vga_hs, vga_vs, vga_blank_n, vga_r, vga_g, vga_b, frame_start
    );

endinterface

// File: rtl/vga_timing.sv
// Pixel-enable divider, h/v counters and raw (unregistered) sync/active terms.
module vga_timing
    import ship_vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic   clk,
    input  logic   reset_n,
    output logic   pix_en,
    output coord_t h_cnt,
    output coord_t v_cnt,
    output logic   hs_term,
    output logic   vs_term,
    output logic   active
);

    localparam int     HT       = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int     VT       = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam coord_t H_LAST   = coord_t'(HT - 1);
    localparam coord_t V_LAST   = coord_t'(VT - 1);
    localparam coord_t HS_START = coord_t'(H_ACTIVE + H_FP);
    localparam coord_t HS_END   = coord_t'(H_ACTIVE + H_FP + H_SYNC);
    localparam coord_t VS_START = coord_t'(V_ACTIVE + V_FP);
    localparam coord_t VS_END   = coord_t'(V_ACTIVE + V_FP + V_SYNC);

    logic h_wrap;

    assign h_wrap = pix_en && (h_cnt == H_LAST);

    // pix_en alternates every clk, so the counters move at half the clk rate.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pix_en <= 1'b0;
            h_cnt  <= '0;
            v_cnt  <= '0;
        end else begin
            pix_en <= ~pix_en;
            if (pix_en) begin
                h_cnt <= h_wrap ? '0 : h_cnt + coord_t'(1);
            end
            if (h_wrap) begin
                v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + coord_t'(1);
            end
        end
    end

    assign hs_term = !((h_cnt >= HS_START) && (h_cnt < HS_END));
    assign vs_term = !((v_cnt >= VS_START) && (v_cnt < VS_END));
    assign active  = (h_cnt < coord_t'(H_ACTIVE)) && (v_cnt < coord_t'(V_ACTIVE));

endmodule

// File: rtl/ship_rect_vga.sv
// Draws one solid rectangle over a background on a VGA raster.
// Define RECT_OUTLINE_EN to draw only the rectangle's one-pixel border.
module ship_rect_vga
    import ship_vga_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP
) (
    input  logic            clk,
    input  logic            reset_n,
    ship_rect_vga_if.slave  bus
);

    logic   pix_en;
    coord_t h_cnt;
    coord_t v_cnt;
    logic   hs_term;
    logic   vs_term;
    logic   active;

    vga_timing #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP)
    ) u_timing (
        .clk     (clk),
        .reset_n (reset_n),
        .pix_en  (pix_en),
        .h_cnt   (h_cnt),
        .v_cnt   (v_cnt),
        .hs_term (hs_term),
        .vs_term (vs_term),
        .active  (active)
    );

    rect_t shadow;
    logic  load_tick;
    logic  in_x;
    logic  in_y;
    logic  hit;

    // Geometry only changes at the first blanked line, so a frame never tears.
    assign load_tick       = pix_en && (h_cnt == '0) && (v_cnt == coord_t'(V_ACTIVE));
    assign bus.frame_start = load_tick;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
        end else if (load_tick) begin
            shadow.px <= {1'b0, bus.pos_x};
            shadow.py <= {1'b0, bus.pos_y};
            shadow.sx <= {1'b0, bus.size_x};
            shadow.sy <= {1'b0, bus.size_y};
        end
    end

    assign in_x = in_span(h_cnt, shadow.px, shadow.sx);
    assign in_y = in_span(v_cnt, shadow.py, shadow.sy);

`ifdef RECT_OUTLINE_EN
    assign hit = in_x && in_y &&
                 ((h_cnt == shadow.px) || (h_cnt == shadow.px + shadow.sx - coord_t'(1)) ||
                  (v_cnt == shadow.py) || (v_cnt == shadow.py + shadow.sy - coord_t'(1)));
`else
    assign hit = in_x && in_y;
`endif

    logic hit_s1, hs_s1, vs_s1, act_s1;
    logic hs_s2, vs_s2, blank_n_s2;
    rgb_t colour_s2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hit_s1     <= 1'b0;
            hs_s1      <= 1'b1;
            vs_s1      <= 1'b1;
            act_s1     <= 1'b0;
            hs_s2      <= 1'b1;
            vs_s2      <= 1'b1;
            blank_n_s2 <= 1'b0;
            colour_s2  <= '0;
        end else if (pix_en) begin
            hit_s1     <= hit;
            hs_s1      <= hs_term;
            vs_s1      <= vs_term;
            act_s1     <= active;
            hs_s2      <= hs_s1;
            vs_s2      <= vs_s1;
            blank_n_s2 <= act_s1;
            // Colours are deliberately live, not shadowed.
            colour_s2  <= !act_s1 ? '0 : (hit_s1 ? bus.fg_rgb : bus.bg_rgb);
        end
    end

    assign bus.vga_hs      = hs_s2;
    assign bus.vga_vs      = vs_s2;
    assign bus.vga_blank_n = blank_n_s2;
    assign bus.vga_r       = colour_s2[23:16];
    assign bus.vga_g       = colour_s2[15:8];
    assign bus.vga_b       = colour_s2[7:0];

endmodule

// File: tb/tb_ship_rect_vga.sv
// Directed bench for ship_rect_vga on a reduced raster (32x24 visible, 44x30 total).
// Honours RECT_OUTLINE_EN for the outline-mode expectations.
module tb_ship_rect_vga;

  localparam int HA = 32, HF = 4, HS = 4, HB = 4, HT = HA + HF + HS + HB;
  localparam int VA = 24, VF = 2, VS = 2, VB = 2, VT = VA + VF + VS + VB;
  localparam int FRAME = HT * VT;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int total = 0;
  int bad = 0;

  always #10 clk = ~clk;

  ship_rect_vga_if bus();

  ship_rect_vga #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .bus(bus)
  );

  // Independent raster position model, built from the timing description.
  logic m_pix;
  int m_h, m_v;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pix <= 1'b0; m_h <= 0; m_v <= 0;
    end else begin
      m_pix <= ~m_pix;
      if (m_pix) begin
        if (m_h == HT - 1) begin
          m_h <= 0;
          m_v <= (m_v == VT - 1) ? 0 : m_v + 1;
        end else begin
          m_h <= m_h + 1;
        end
      end
    end
  end

  // Advance to the negedge right after the next pixel tick.
  task automatic next_tick();
    do @(negedge clk); while (m_pix !== 1'b0);
  endtask

  // Raster coordinate currently on the outputs (two ticks behind the counters).
  task automatic out_coord(output int oh, output int ov);
    int idx;
    idx = m_v * HT + m_h - 2;
    if (idx < 0) idx += FRAME;
    oh = idx % HT;
    ov = idx / HT;
  endtask

  function automatic logic [26:0] exp_pix(int h, int v, int px, int py, int sx, int sy,
                                          logic [23:0] fg, logic [23:0] bg);
    logic hs, vs, act, hit;
    hs  = !(h >= HA + HF && h < HA + HF + HS);
    vs  = !(v >= VA + VF && v < VA + VF + VS);
    act = (h < HA) && (v < VA);
    hit = (h >= px) && (h < px + sx) && (v >= py) && (v < py + sy);
`ifdef RECT_OUTLINE_EN
    hit = hit && (h == px || h == px + sx - 1 || v == py || v == py + sy - 1);
`endif
    return {hs, vs, act, act ? (hit ? fg : bg) : 24'h0};
  endfunction

  task automatic set_rect(input int px, input int py, input int sx, input int sy,
                          input logic [23:0] fg, input logic [23:0] bg);
    bus.pos_x  = 10'(px);
    bus.pos_y  = 10'(py);
    bus.size_x = 10'(sx);
    bus.size_y = 10'(sy);
    bus.fg_rgb = fg;
    bus.bg_rgb = bg;
  endtask

  // Step until the model counters are just past the next shadow-load point.
  task automatic wait_load();
    int n;
    n = 0;
    do begin
      next_tick();
      n++;
    end while (!(m_v == VA && m_h == 1) && n < 2 * FRAME);
  endtask

  // Observe one full output frame from pixel (0,0); nbad = -1 on timeout.
  task automatic scan_frame(input int px, input int py, input int sx, input int sy,
                            input logic [23:0] fg, input logic [23:0] bg,
                            input int mid_v, input int mid_px,
                            output int nbad, output int fg_cnt, output string first);
    int oh, ov, n;
    logic [26:0] e, a;
    nbad = 0; fg_cnt = 0; first = "";
    n = 0;
    out_coord(oh, ov);
    while (!(oh == 0 && ov == 0) && n < 3 * FRAME) begin
      next_tick();
      n++;
      out_coord(oh, ov);
    end
    if (!(oh == 0 && ov == 0)) begin
      nbad = -1;
      first = "timeout waiting for frame origin";
      return;
    end
    for (int i = 0; i < FRAME; i++) begin
      out_coord(oh, ov);
      if (mid_v >= 0 && m_v == mid_v && m_h == 0) bus.pos_x = 10'(mid_px);
      e = exp_pix(oh, ov, px, py, sx, sy, fg, bg);
      a = {bus.vga_hs, bus.vga_vs, bus.vga_blank_n, bus.vga_r, bus.vga_g, bus.vga_b};
      if (a !== e) begin
        if (nbad == 0) first = $sformatf("x=%0d y=%0d got %h want %h", oh, ov, a, e);
        nbad++;
      end
      if (bus.vga_blank_n === 1'b1 && {bus.vga_r, bus.vga_g, bus.vga_b} === fg) fg_cnt++;
      next_tick();
    end
  endtask

  task automatic test_reset();
    set_rect(0, 0, 0, 0, 24'h0, 24'h0);
    reset_n = 1'b0;
    repeat (3) @(negedge clk);
    total++; if (bus.vga_hs !== 1'b1) begin bad++; $display("FAIL reset_hs got %b want 1", bus.vga_hs); end
    total++; if (bus.vga_vs !== 1'b1) begin bad++; $display("FAIL reset_vs got %b want 1", bus.vga_vs); end
    total++; if (bus.vga_blank_n !== 1'b0) begin bad++; $display("FAIL reset_blank got %b want 0", bus.vga_blank_n); end
    total++; if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 24'h0) begin
      bad++; $display("FAIL reset_rgb got %h want 000000", {bus.vga_r, bus.vga_g, bus.vga_b}); end
    total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL reset_fs got %b want 0", bus.frame_start); end
    reset_n = 1'b1;
  endtask

  task automatic test_sync();
    int n, low, first_h, first_v;
    n = 0;
    while (bus.vga_hs !== 1'b0 && n < 2 * HT) begin next_tick(); n++; end
    first_h = m_h; first_v = m_v;
    total++; if (first_h !== HA + HF + 2 || first_v !== 0) begin
      bad++; $display("FAIL hs_first counter at h=%0d v=%0d want h=%0d v=0", first_h, first_v, HA + HF + 2); end
    low = 0;
    while (bus.vga_hs === 1'b0 && low < 2 * HT) begin next_tick(); low++; end
    total++; if (low !== HS) begin bad++; $display("FAIL hs_width got %0d want %0d", low, HS); end
    n = low;
    while (bus.vga_hs !== 1'b0 && n < 2 * HT) begin next_tick(); n++; end
    total++; if (n !== HT) begin bad++; $display("FAIL hs_period got %0d want %0d", n, HT); end
    n = 0;
    while (bus.vga_vs !== 1'b0 && n < 2 * FRAME) begin next_tick(); n++; end
    total++; if (m_v !== VA + VF || m_h !== 2) begin
      bad++; $display("FAIL vs_first counter at h=%0d v=%0d want h=2 v=%0d", m_h, m_v, VA + VF); end
    low = 0;
    while (bus.vga_vs === 1'b0 && low < 2 * FRAME) begin next_tick(); low++; end
    total++; if (low !== VS * HT) begin bad++; $display("FAIL vs_width got %0d want %0d", low, VS * HT); end
  endtask

  task automatic test_frame_start();
    int cnt;
    logic pos_ok;
    cnt = 0; pos_ok = 1'b1;
    for (int i = 0; i < 2 * FRAME; i++) begin
      @(negedge clk);
      if (bus.frame_start === 1'b1) begin
        cnt++;
        if (!(m_pix === 1'b1 && m_h == 0 && m_v == VA)) pos_ok = 1'b0;
      end
    end
    total++; if (cnt !== 1) begin bad++; $display("FAIL fs_count got %0d want 1", cnt); end
    total++; if (pos_ok !== 1'b1) begin bad++; $display("FAIL fs_position got off-position pulse want h=0 v=%0d", VA); end
  endtask

  task automatic test_fill();
    int nbad, fgc; string first;
    set_rect(10, 5, 8, 4, 24'hFF0000, 24'h000080);
    wait_load();
    scan_frame(10, 5, 8, 4, 24'hFF0000, 24'h000080, -1, 0, nbad, fgc, first);
    total++; if (nbad !== 0) begin bad++; $display("FAIL fill_pixels bad=%0d first: %s", nbad, first); end
`ifdef RECT_OUTLINE_EN
    total++; if (fgc !== 20) begin bad++; $display("FAIL fill_fg_count got %0d want 20", fgc); end
`else
    total++; if (fgc !== 32) begin bad++; $display("FAIL fill_fg_count got %0d want 32", fgc); end
`endif
  endtask

  task automatic test_midframe();
    int nbad, fgc; string first;
    scan_frame(10, 5, 8, 4, 24'hFF0000, 24'h000080, 15, 20, nbad, fgc, first);
    total++; if (nbad !== 0) begin bad++; $display("FAIL mid_old_frame bad=%0d first: %s", nbad, first); end
    scan_frame(20, 5, 8, 4, 24'hFF0000, 24'h000080, -1, 0, nbad, fgc, first);
    total++; if (nbad !== 0) begin bad++; $display("FAIL mid_new_frame bad=%0d first: %s", nbad, first); end
  endtask

  task automatic test_edge_clip();
    int nbad, fgc; string first;
    set_rect(28, 21, 10, 10, 24'h00FF00, 24'h101010);
    wait_load();
    scan_frame(28, 21, 10, 10, 24'h00FF00, 24'h101010, -1, 0, nbad, fgc, first);
    total++; if (nbad !== 0) begin bad++; $display("FAIL edge_pixels bad=%0d first: %s", nbad, first); end
`ifdef RECT_OUTLINE_EN
    total++; if (fgc !== 6) begin bad++; $display("FAIL edge_fg_count got %0d want 6", fgc); end
`else
    total++; if (fgc !== 12) begin bad++; $display("FAIL edge_fg_count got %0d want 12", fgc); end
`endif
  endtask

  task automatic test_zero_size();
    int nbad, fgc; string first;
    set_rect(3, 3, 0, 6, 24'hABCDEF, 24'h123456);
    wait_load();
    scan_frame(3, 3, 0, 6, 24'hABCDEF, 24'h123456, -1, 0, nbad, fgc, first);
    total++; if (nbad !== 0) begin bad++; $display("FAIL zero_pixels bad=%0d first: %s", nbad, first); end
    total++; if (fgc !== 0) begin bad++; $display("FAIL zero_fg_count got %0d want 0", fgc); end
  endtask

  task automatic test_small_rect();
    int nbad, fgc; string first;
    set_rect(2, 2, 4, 4, 24'hFFFFFF, 24'h000000);
    wait_load();
    scan_frame(2, 2, 4, 4, 24'hFFFFFF, 24'h000000, -1, 0, nbad, fgc, first);
    total++; if (nbad !== 0) begin bad++; $display("FAIL small_pixels bad=%0d first: %s", nbad, first); end
`ifdef RECT_OUTLINE_EN
    total++; if (fgc !== 12) begin bad++; $display("FAIL small_fg_count got %0d want 12", fgc); end
`else
    total++; if (fgc !== 16) begin bad++; $display("FAIL small_fg_count got %0d want 16", fgc); end
`endif
  endtask

  task automatic test_reset_mid();
    int nbad, fgc, n; string first;
    set_rect(10, 5, 8, 4, 24'hFF0000, 24'h000080);
    wait_load();
    n = 0;
    while (!(m_v == 15 && m_h == 20) && n < 2 * FRAME) begin next_tick(); n++; end
    #3 reset_n = 1'b0;
    #1;
    total++; if (bus.vga_hs !== 1'b1 || bus.vga_vs !== 1'b1) begin
      bad++; $display("FAIL midrst_sync got hs=%b vs=%b want 1 1", bus.vga_hs, bus.vga_vs); end
    total++; if (bus.vga_blank_n !== 1'b0) begin bad++; $display("FAIL midrst_blank got %b want 0", bus.vga_blank_n); end
    total++; if ({bus.vga_r, bus.vga_g, bus.vga_b} !== 24'h0) begin
      bad++; $display("FAIL midrst_rgb got %h want 000000", {bus.vga_r, bus.vga_g, bus.vga_b}); end
    total++; if (bus.frame_start !== 1'b0) begin bad++; $display("FAIL midrst_fs got %b want 0", bus.frame_start); end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    // Inputs still describe a rectangle, but shadows restart empty.
    scan_frame(0, 0, 0, 0, 24'hFF0000, 24'h000080, -1, 0, nbad, fgc, first);
    total++; if (nbad !== 0) begin bad++; $display("FAIL midrst_frame bad=%0d first: %s", nbad, first); end
    total++; if (fgc !== 0) begin bad++; $display("FAIL midrst_fg_count got %0d want 0", fgc); end
  endtask

  initial begin
    test_reset();
    test_sync();
    test_frame_start();
    test_fill();
    test_midframe();
    test_edge_clip();
    test_zero_size();
    test_small_rect();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ship_rect_vga.md
SHIP_RECT_VGA -- requirements
Module: ship_rect_vga

Interface
REQ-001 Parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 Parameter V_ACTIVE, default 480, visible lines per frame.
REQ-003 Parameter H_FP/H_SYNC/H_BP, default 16/96/48, horizontal porch and sync widths in pixels.
REQ-004 Parameter V_FP/V_SYNC/V_BP, default 10/2/33, vertical porch and sync widths in lines.
REQ-005 Port clk, input, 1, 50 MHz system clock, the only clock.
REQ-006 Port reset_n, input, 1, asynchronous active-low reset.
REQ-007 Ports size_x, size_y, input, 10 each, ship rectangle width and height from PIO out_port.
REQ-008 Ports pos_x, pos_y, input, 10 each, rectangle top-left corner from PIO out_port.
REQ-009 Ports fg_rgb and bg_rgb, input, 24 each, rectangle colour and background colour.
REQ-010 Port vga_hs and vga_vs, output, 1 each, active-low sync pulses.
REQ-011 Port vga_blank_n, output, 1, high during the visible area.
REQ-012 Port vga_r, vga_g, vga_b, output, 8 each, pixel colour.
REQ-013 Port frame_start, output, 1, single-clk pulse when shadow registers load.

Function
REQ-014 pix_en SHALL toggle every clk, so counters advance every second clk (25 MHz pixel rate).
REQ-015 h_cnt SHALL count 0..H_TOTAL-1 on pix_en, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (800), and wrap to 0.
REQ-016 v_cnt SHALL increment on h_cnt wrap over 0..V_TOTAL-1 (525) and wrap to 0.
REQ-017 The hsync term SHALL be low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; vsync SHALL follow the same rule on v_cnt.
REQ-018 size/pos inputs SHALL be captured into shadow registers only on the pix_en tick where h_cnt==0 and v_cnt==V_ACTIVE; frame_start SHALL pulse on that clk.
REQ-019 Hit test SHALL use 11-bit arithmetic: hit = (h>=px)&&(h<px+sx)&&(v>=py)&&(v<py+sy), with no overflow wrap.
REQ-020 size_x==0 or size_y==0 SHALL produce no hit pixels.
REQ-021 Rectangles extending past H_ACTIVE/V_ACTIVE SHALL be clipped by blanking, with no wrap to column or line 0.
REQ-022 Pipeline stage 1 SHALL register the hit flag and the sync/blank terms.
REQ-023 Pipeline stage 2 SHALL register the colour: fg_rgb if hit&&active, bg_rgb if active&&!hit, 0 if blanked.
REQ-024 All VGA outputs SHALL be aligned, with a latency of 2 pix_en ticks from counter value.
REQ-025 fg_rgb/bg_rgb SHALL NOT be shadowed and SHALL be sampled live in stage 2.

Reset
REQ-026 reset_n low SHALL asynchronously clear pix_en, h_cnt, v_cnt, shadows, and both pipeline stages.
REQ-027 During reset, outputs SHALL be: vga_hs=1, vga_vs=1, vga_blank_n=0, rgb=0, frame_start=0.
REQ-028 Reset asserted mid-frame SHALL restart the frame at h=0, v=0 with zero shadows (no rectangle) until the first frame_start.

Configuration
REQ-029 With RECT_OUTLINE_EN defined, hit SHALL be true only on rectangle edge pixels (h==px, h==px+sx-1, v==py, or v==py+sy-1, inside bounds).
REQ-030 With RECT_OUTLINE_EN undefined, the rectangle SHALL be filled per REQ-019.

Structure
REQ-031 Package ship_vga_pkg SHALL hold the default timing constants, H_TOTAL/V_TOTAL, and a coord_t (11-bit) typedef.
REQ-032 Counters and sync generation SHALL live in sub-module vga_timing; ship_rect_vga SHALL hold the shadows, hit pipeline and colour mux.

Verification
REQ-033 Reset release -> first vga_hs low exactly 2 ticks after h_cnt=656; hs period 800 ticks; vs low for 2 lines starting at v=490.
REQ-034 pos=(100,50), size=(20,10), fg=FF0000, bg=000080 -> red at pixels x100..119 on lines y50..59 and 000080 elsewhere in the active area; the frame after load is checked at 2-tick latency.
REQ-035 Change pos_x mid-frame at v=200 -> current frame unchanged; new position visible only after the frame_start at v=480.
REQ-036 pos=(630,475), size=(20,20) -> lit only x630..639 and y475..479; column 0 and line 0 stay bg.
REQ-037 size_x=0 -> no fg pixels in the full frame; with RECT_OUTLINE_EN and size=(4,4), exactly 12 fg pixels.
REQ-038 reset_n pulse at v=300 -> outputs take reset values immediately, and the next frame starts at h=0, v=0 with no rectangle.
